n2_com_dp_64x84_fifo_ctl: RTL and testbench

Controller that turns the 64-entry × 84-bit two-port register-file array into an in-order FIFO with valid/ready push and pop handshakes. It owns the array's write and read address, enable and data ports, and hides the array's one-cycle synchronous read latency behind a 2-entry output skid buffer. The skid buffer sustains one pop per cycle. The block sits between a producer and a consumer in the same clock domain, with the array instantiated alongside it.

---
 rtl/n2_com_dp_64x84_fifo_ctl.sv | 85 ++++++++
 tb/tb_n2_com_dp_64x84_fifo_ctl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/n2_com_dp_64x84_fifo_ctl.sv
// n2_com_dp_64x84_fifo_ctl: in-order FIFO controller over a 64x84 two-port array with a 2-entry output skid buffer.
// Ports: l2clk/reset; push_vld/push_rdy/push_data producer side; pop_vld/pop_rdy/pop_data consumer side;
// flush empties everything, wr_inhibit blocks pushes; count/almost_full report total occupancy;
// ary_* drive the array write/read ports, ary_dout returns read data one cycle after ary_rd_en.
module n2_com_dp_64x84_fifo_ctl #(
    parameter int DEPTH        = 64,
    parameter int WIDTH        = 84,
    parameter int AFULL_THRESH = 56
) (
    input  logic             l2clk,
    input  logic             reset,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    input  logic             wr_inhibit,
    output logic [6:0]       count,
    output logic             almost_full,
    output logic             ary_wr_en,
    output logic [5:0]       ary_wr_adr,
    output logic [WIDTH-1:0] ary_din,
    output logic             ary_rd_en,
    output logic [5:0]       ary_rd_adr,
    input  logic [WIDTH-1:0] ary_dout
);
    logic [6:0]       wp_q, wp_d, rp_q, rp_d, count_q, count_d, aocc;
    logic [1:0]       bcnt_q, bcnt_d, nb;
    logic             inflt_q, inflt_d, af_q, af_d, rst_dly_q, rst_dly_d;
    logic             blk, push_fire, pop_fire, rd_issue, cap;
    logic [WIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
    always_comb begin
        // blk keeps every handshake quiet through the cycle after reset as well
        blk       = reset | rst_dly_q;
        rst_dly_d = reset;
        aocc      = wp_q - rp_q;
        push_rdy  = ~blk & ~flush & ~wr_inhibit & (aocc < 7'(DEPTH));
        push_fire = push_vld & push_rdy;
        pop_vld   = ~blk & ~flush & (bcnt_q != 2'd0);
        pop_fire  = pop_vld & pop_rdy;
        // issue only if the skid buffer can absorb the returning word after this cycle's pop
        rd_issue  = ~blk & ~flush & (aocc != 7'd0) &
                    (({1'b0, bcnt_q} + {2'b0, inflt_q}) < (3'd2 + {2'b0, pop_fire}));
        cap       = inflt_q & ~flush;
        nb        = bcnt_q - {1'b0, pop_fire};
        b0_d      = (cap && nb == 2'd0) ? ary_dout : pop_fire ? b1_q : b0_q;
        b1_d      = (cap && nb == 2'd1) ? ary_dout : b1_q;
        wp_d      = flush ? 7'd0 : wp_q + {6'd0, push_fire};
        rp_d      = flush ? 7'd0 : rp_q + {6'd0, rd_issue};
        bcnt_d    = flush ? 2'd0 : nb + {1'b0, cap};
        inflt_d   = ~flush & rd_issue;
        count_d   = flush ? 7'd0 : count_q + {6'd0, push_fire} - {6'd0, pop_fire};
        af_d      = ~flush & (count_d >= 7'(AFULL_THRESH));
        ary_wr_en  = push_fire;
        ary_wr_adr = push_fire ? wp_q[5:0] : 6'd0;
        ary_din    = push_data;
        ary_rd_en  = rd_issue;
        ary_rd_adr = rd_issue ? rp_q[5:0] : 6'd0;
        pop_data   = b0_q;
        count      = reset ? 7'd0 : count_q;
        almost_full = ~reset & af_q;
    end
    always_ff @(posedge l2clk) begin
        rst_dly_q <= rst_dly_d;
        b0_q      <= b0_d;
        b1_q      <= b1_d;
        if (reset) begin
            wp_q    <= 7'd0;
            rp_q    <= 7'd0;
            bcnt_q  <= 2'd0;
            inflt_q <= 1'b0;
            count_q <= 7'd0;
            af_q    <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            bcnt_q  <= bcnt_d;
            inflt_q <= inflt_d;
            count_q <= count_d;
            af_q    <= af_d;
        end
    end
endmodule

// File: tb/tb_n2_com_dp_64x84_fifo_ctl.sv
// tb_n2_com_dp_64x84_fifo_ctl: vector table plus scoreboard bench for the 64x84 FIFO controller.
module tb_n2_com_dp_64x84_fifo_ctl;
    logic        l2clk = 1'b0;
    logic        reset = 1'b1, push_vld = 1'b0, pop_rdy = 1'b0, flush = 1'b0, wr_inhibit = 1'b0;
    logic [83:0] push_data = '0, pop_data, ary_din, ary_dout;
    logic        push_rdy, pop_vld, almost_full, ary_wr_en, ary_rd_en;
    logic [6:0]  count;
    logic [5:0]  ary_wr_adr, ary_rd_adr;
    logic [83:0] mem [64];

    always #5 l2clk = ~l2clk;

    n2_com_dp_64x84_fifo_ctl dut (
        .l2clk(l2clk), .reset(reset), .push_vld(push_vld), .push_rdy(push_rdy), .push_data(push_data),
        .pop_vld(pop_vld), .pop_rdy(pop_rdy), .pop_data(pop_data), .flush(flush), .wr_inhibit(wr_inhibit),
        .count(count), .almost_full(almost_full), .ary_wr_en(ary_wr_en), .ary_wr_adr(ary_wr_adr),
        .ary_din(ary_din), .ary_rd_en(ary_rd_en), .ary_rd_adr(ary_rd_adr), .ary_dout(ary_dout)
    );

    always @(posedge l2clk) begin
        if (ary_wr_en) mem[ary_wr_adr] <= ary_din;
        if (ary_rd_en) ary_dout <= mem[ary_rd_adr];
    end

    typedef struct {
        logic rst, pv; logic [83:0] pd; logic pr, fl, inh;
        logic e_prdy, e_pvld, e_wen, e_ren; logic [5:0] e_wadr, e_radr; logic [6:0] e_cnt; logic [83:0] e_pd;
    } vec_t;

    int ntests = 0, nfail = 0, cyc = 0, acc = 0, pops = 0, first_pop = -1, last_pop = -1;
    int wp_m = 0, rp_m = 0;
    logic [83:0] q [$];

    task automatic chk(input string nm, input logic [83:0] a, input logic [83:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic drv(input logic r, input logic pv, input logic [83:0] pd, input logic pr,
                       input logic fl, input logic inh);
        @(negedge l2clk);
        cyc++;
        reset = r; push_vld = pv; push_data = pd; pop_rdy = pr; flush = fl; wr_inhibit = inh;
    endtask

    task automatic smp();
        int ec;
        #1;
        ec = reset ? 0 : q.size();
        chk("count", count, 84'(ec));
        chk("almost_full", almost_full, 84'(ec >= 56));
        chk("wr_en", ary_wr_en, push_vld & push_rdy);
        if (ary_wr_en) begin
            chk("wr_adr", ary_wr_adr, 84'(wp_m % 64));
            chk("din", ary_din, push_data);
        end
        if (ary_rd_en) chk("rd_adr", ary_rd_adr, 84'(rp_m % 64));
        if (push_vld && push_rdy) begin q.push_back(push_data); wp_m++; acc++; end
        if (ary_rd_en) rp_m++;
        if (pop_vld && pop_rdy) begin
            if (q.size() == 0) begin
                ntests++; nfail++;
                $display("FAIL pop_underflow: got %0h expected nothing", pop_data);
            end else chk("pop_data", pop_data, q.pop_front());
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (reset || flush) begin q.delete(); wp_m = 0; rp_m = 0; end
    endtask

    function automatic vec_t mk(logic rst, logic pv, logic [83:0] pd, logic pr, logic fl, logic inh,
                                logic e_prdy, logic e_pvld, logic e_wen, logic e_ren,
                                logic [5:0] e_wadr, logic [5:0] e_radr, logic [6:0] e_cnt, logic [83:0] e_pd);
        vec_t v;
        v.rst = rst; v.pv = pv; v.pd = pd; v.pr = pr; v.fl = fl; v.inh = inh;
        v.e_prdy = e_prdy; v.e_pvld = e_pvld; v.e_wen = e_wen; v.e_ren = e_ren;
        v.e_wadr = e_wadr; v.e_radr = e_radr; v.e_cnt = e_cnt; v.e_pd = e_pd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [9];
        int base, p0, s;
        logic stale;
        for (int i = 0; i < 3; i++)
            tv[i] = mk(1, 1'($urandom), 84'({$urandom, $urandom, $urandom}), 1'($urandom), 1'($urandom),
                       1'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
        tv[3] = mk(0, 1, 84'hA5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[4] = mk(0, 1, 84'hA5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        tv[5] = mk(0, 0, 84'h0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        tv[6] = mk(0, 0, 84'h0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tv[7] = mk(0, 0, 84'h0,  1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 84'hA5);
        tv[8] = mk(0, 0, 84'h0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drv(tv[i].rst, tv[i].pv, tv[i].pd, tv[i].pr, tv[i].fl, tv[i].inh);
            smp();
            chk($sformatf("v%0d push_rdy", i), push_rdy, tv[i].e_prdy);
            chk($sformatf("v%0d pop_vld", i), pop_vld, tv[i].e_pvld);
            chk($sformatf("v%0d wr_en", i), ary_wr_en, tv[i].e_wen);
            chk($sformatf("v%0d rd_en", i), ary_rd_en, tv[i].e_ren);
            chk($sformatf("v%0d wr_adr", i), ary_wr_adr, tv[i].e_wadr);
            chk($sformatf("v%0d rd_adr", i), ary_rd_adr, tv[i].e_radr);
            chk($sformatf("v%0d count", i), count, tv[i].e_cnt);
            chk($sformatf("v%0d almost_full", i), almost_full, 0);
            if (tv[i].e_pvld) chk($sformatf("v%0d pop_data", i), pop_data, tv[i].e_pd);
        end

        // fill with consumer stalled: 66 accepted out of 70 offered
        base = acc;
        for (int c = 0; c < 90; c++) begin
            drv(0, (acc - base) < 70, 84'(acc - base), 0, 0, 0);
            smp();
        end
        chk("fill accepted", 84'(acc - base), 84'd66);
        chk("fill count", count, 84'd66);
        chk("fill push_rdy", push_rdy, 0);
        chk("fill almost_full", almost_full, 1);
        p0 = pops;
        for (int c = 0; c < 200 && (pops - p0) < 66; c++) begin
            drv(0, 0, 0, 1, 0, 0);
            smp();
            if (c == 0) chk("drain0 push_rdy", push_rdy, 0);
            if (c == 1) chk("drain1 push_rdy", push_rdy, 1);
        end
        chk("drain pops", 84'(pops - p0), 84'd66);

        // streaming 200 values through the wrapping pointers
        base = acc; p0 = pops; first_pop = -1; s = cyc + 1;
        for (int c = 0; c < 300 && (pops - p0) < 200; c++) begin
            drv(0, (acc - base) < 200, 84'(1000 + acc - base), 1, 0, 0);
            smp();
            if (c == 199) chk("stream push per cycle", 84'(acc - base), 84'd200);
        end
        chk("stream pops", 84'(pops - p0), 84'd200);
        chk("stream latency", 84'(first_pop - s), 84'd3);
        chk("stream one pop per cycle", 84'(last_pop - first_pop), 84'd199);

        // flush with a read outstanding
        for (int i = 0; i < 10; i++) begin drv(0, 1, 84'(2000 + i), 0, 0, 0); smp(); end
        for (int i = 0; i < 4; i++) begin drv(0, 0, 0, 0, 0, 0); smp(); end
        drv(0, 0, 0, 1, 0, 0); smp();
        chk("pre-flush rd_en", ary_rd_en, 1);
        drv(0, 1, 84'h55, 1, 1, 0); smp();
        chk("flush push_rdy", push_rdy, 0);
        chk("flush pop_vld", pop_vld, 0);
        chk("flush rd_en", ary_rd_en, 0);
        drv(0, 0, 0, 1, 0, 0); smp();
        chk("post-flush count", count, 0);
        chk("post-flush pop_vld", pop_vld, 0);
        drv(0, 1, 84'h1, 1, 0, 0); smp();
        p0 = pops;
        for (int c = 0; c < 10 && pops == p0; c++) begin
            drv(0, 0, 0, 1, 0, 0); smp();
            if (pop_vld) chk("post-flush data", pop_data, 84'h1);
        end
        chk("post-flush pops", 84'(pops - p0), 1);
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin drv(0, 0, 0, 1, 0, 0); smp(); stale |= pop_vld; end
        chk("no stale data", stale, 0);

        // inhibit blocks pushes but the FIFO keeps draining
        for (int i = 0; i < 5; i++) begin drv(0, 1, 84'(3000 + i), 0, 0, 0); smp(); end
        p0 = pops;
        for (int c = 0; c < 15; c++) begin
            drv(0, 1, 84'h99, 1, 0, 1); smp();
            chk("inhibit push_rdy", push_rdy, 0);
        end
        chk("inhibit drained", 84'(pops - p0), 84'd5);

        // reset in mid-stream discards contents
        for (int i = 0; i < 4; i++) begin drv(0, 1, 84'(4000 + i), 0, 0, 0); smp(); end
        for (int i = 0; i < 2; i++) begin drv(1, 1, 84'h3, 1, 0, 0); smp(); end
        drv(0, 1, 84'h3, 1, 0, 0); smp();
        chk("post-reset push_rdy", push_rdy, 0);
        chk("post-reset pop_vld", pop_vld, 0);
        drv(0, 1, 84'h7, 1, 0, 0); smp();
        chk("reset recovery push_rdy", push_rdy, 1);
        p0 = pops;
        for (int c = 0; c < 10 && pops == p0; c++) begin drv(0, 0, 0, 1, 0, 0); smp(); end
        chk("reset recovery pops", 84'(pops - p0), 1);
        chk("scoreboard empty", 84'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
